// File: rtl/store_unit.sv
`default_nettype none
// ============================================================================
// Module   : store_unit
// Purpose  : SB/SH/SW store engine for a word-wide data memory without byte
//            enables; narrow stores use read-modify-write over req/ack.
//            Optional alignment check: define STORE_ALIGN_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module store_unit #(
    parameter int         ACK_TIMEOUT = 16,
    parameter logic [5:0] OPC_SB      = 6'h28,
    parameter logic [5:0] OPC_SH      = 6'h29,
    parameter logic [5:0] OPC_SW      = 6'h2B
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [5:0]  opcode,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    localparam int                c_cnt_w    = $clog2(ACK_TIMEOUT + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD    = 3'd1,
        S_MERGE = 3'd2,
        S_WR    = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [5:0]           r_opcode;
    logic [31:0]          r_addr;
    logic [31:0]          r_data;
    logic [31:0]          r_rdata;
    logic [31:0]          r_wdata;
    logic                 r_err;
    logic [c_cnt_w-1:0]   r_cnt;

    logic                 w_is_sb;
    logic                 w_is_sh;
    logic                 w_is_sw;
    logic                 w_misalign;
    logic                 w_reject;
    logic                 w_timeout;
    logic [31:0]          w_merged;

    assign w_is_sb = (opcode == OPC_SB);
    assign w_is_sh = (opcode == OPC_SH);
    assign w_is_sw = (opcode == OPC_SW);

`ifdef STORE_ALIGN_CHECK_EN
    assign w_misalign = (w_is_sh && addr[0]) || (w_is_sw && (addr[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    assign w_reject  = !(w_is_sb || w_is_sh || w_is_sw) || w_misalign;
    // The limit only fires without an ack, so a last-cycle ack completes cleanly.
    assign w_timeout = !mem_ack && (r_cnt == c_cnt_last);

    assign mem_addr  = {r_addr[31:2], 2'b00};
    assign mem_wdata = r_wdata;

    always_comb begin
        w_merged = r_rdata;
        if (r_opcode == OPC_SH) begin
            if (r_addr[1])
                w_merged[31:16] = r_data[15:0];
            else
                w_merged[15:0]  = r_data[15:0];
        end else begin
            case (r_addr[1:0])
                2'd0:    w_merged[7:0]   = r_data[7:0];
                2'd1:    w_merged[15:8]  = r_data[7:0];
                2'd2:    w_merged[23:16] = r_data[7:0];
                default: w_merged[31:24] = r_data[7:0];
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        busy         = 1'b1;
        done         = 1'b0;
        err          = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    if (w_reject)
                        w_state_next = S_DONE;
                    else if (w_is_sw)
                        w_state_next = S_WR;
                    else
                        w_state_next = S_RD;
                end
            end
            S_RD: begin
                mem_req = 1'b1;
                if (mem_ack)
                    w_state_next = S_MERGE;
                else if (w_timeout)
                    w_state_next = S_DONE;
            end
            S_MERGE: w_state_next = S_WR;
            S_WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                if (mem_ack || w_timeout)
                    w_state_next = S_DONE;
            end
            S_DONE: begin
                done         = 1'b1;
                err          = r_err;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_opcode <= '0;
            r_addr   <= '0;
            r_data   <= '0;
            r_rdata  <= '0;
            r_wdata  <= '0;
            r_err    <= 1'b0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_opcode <= opcode;
                        r_addr   <= addr;
                        r_data   <= store_data;
                        r_wdata  <= store_data;
                        r_err    <= w_reject;
                    end
                end
                S_RD: begin
                    if (mem_ack)
                        r_rdata <= mem_rdata;
                    else if (w_timeout)
                        r_err <= 1'b1;
                end
                S_MERGE: r_wdata <= w_merged;
                S_WR: begin
                    if (w_timeout)
                        r_err <= 1'b1;
                end
                default: ;
            endcase
            // Counter is held at zero outside the wait states, so it restarts on each entry.
            if ((r_state == S_RD) || (r_state == S_WR)) begin
                if (!mem_ack)
                    r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_store_unit
// Purpose  : Self-checking bench for store_unit with a scoreboarded memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_store_unit;

    localparam logic [5:0] c_sb = 6'h28;
    localparam logic [5:0] c_sh = 6'h29;
    localparam logic [5:0] c_sw = 6'h2B;

    logic        clk;
    logic        reset;
    logic        start;
    logic [5:0]  opcode;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        busy;
    logic        done;
    logic        err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    int          ack_delay = 0;
    logic        ack_en = 1'b1;
    logic [31:0] rd_val = 32'h0;
    int          req_cycles = 0;
    int          wait_cnt = 0;

    store_unit dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .opcode     (opcode),
        .addr       (addr),
        .store_data (store_data),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory responder: acks after ack_delay request cycles and checks each access.
    initial begin
        exp_t e;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (mem_req) req_cycles++;
            if (mem_req && !mem_ack && ack_en && !reset) begin
                if (wait_cnt >= ack_delay) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rd_val;
                    wait_cnt  = 0;
                    tests++;
                    if (sb.size() == 0) begin
                        fails++;
                        $display("FAIL mem_access: unexpected access we=%b addr=%h wdata=%h", mem_we, mem_addr, mem_wdata);
                    end else begin
                        e = sb.pop_front();
                        if (mem_we !== e.we || mem_addr !== e.addr || (e.we && mem_wdata !== e.wdata)) begin
                            fails++;
                            $display("FAIL mem_access: got we=%b addr=%h wdata=%h, expected we=%b addr=%h wdata=%h",
                                     mem_we, mem_addr, mem_wdata, e.we, e.addr, e.wdata);
                        end
                    end
                end else begin
                    wait_cnt++;
                end
            end else begin
                mem_ack  = 1'b0;
                wait_cnt = 0;
            end
        end
    end

    function automatic logic [31:0] merge_ref(input logic [5:0] opc, input logic [31:0] a,
                                               input logic [31:0] d, input logic [31:0] old);
        logic [31:0] mask;
        int          sh;
        if (opc == c_sh) begin
            sh   = a[1] ? 16 : 0;
            mask = 32'h0000_FFFF << sh;
        end else begin
            sh   = 8 * int'(a[1:0]);
            mask = 32'h0000_00FF << sh;
        end
        return (old & ~mask) | ((d << sh) & mask);
    endfunction

    function automatic exp_t mk(input logic we, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        e.we = we; e.addr = {a[31:2], 2'b00}; e.wdata = d;
        return e;
    endfunction

    task automatic run_op(input logic [5:0] opc, input logic [31:0] a, input logic [31:0] d,
                          output int lat, output logic e);
        @(negedge clk);
        start = 1'b1; opcode = opc; addr = a; store_data = d;
        @(posedge clk);
        #1 start = 1'b0;
        lat = -1;
        e   = 1'bx;
        for (int k = 1; k <= 64; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = k;
                e   = err;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; opcode = '0; addr = '0; store_data = '0;
        repeat (2) @(negedge clk);
        tests++;
        if ({busy, done, err, mem_req, mem_we} !== 5'b0) begin
            fails++;
            $display("FAIL reset_ctrl: got %b expected 00000", {busy, done, err, mem_req, mem_we});
        end
        tests++;
        if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            fails++;
            $display("FAIL reset_data: got addr=%h wdata=%h expected 0/0", mem_addr, mem_wdata);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_sw;
        int lat; logic e;
        ack_delay = 0;
        sb.push_back(mk(1'b1, 32'h10, 32'hDEADBEEF));
        run_op(c_sw, 32'h0000_0010, 32'hDEADBEEF, lat, e);
        tests++;
        if (lat !== 2 || e !== 1'b0) begin
            fails++;
            $display("FAIL sw_done: got lat=%0d err=%b expected lat=2 err=0", lat, e);
        end
        @(negedge clk);
        tests++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL sw_after: got done=%b busy=%b expected 0/0", done, busy);
        end
    endtask

    task automatic test_sb;
        int lat; logic e;
        rd_val = 32'h11223344;
        sb.push_back(mk(1'b0, 32'h10, 32'h0));
        sb.push_back(mk(1'b1, 32'h10, 32'hA5223344));
        run_op(c_sb, 32'h0000_0013, 32'h0000_00A5, lat, e);
        tests++;
        if (lat !== 4 || e !== 1'b0) begin
            fails++;
            $display("FAIL sb_done: got lat=%0d err=%b expected lat=4 err=0", lat, e);
        end
    endtask

    task automatic test_sh_delay;
        int lat; logic e;
        rd_val    = 32'h11223344;
        ack_delay = 3;
        sb.push_back(mk(1'b0, 32'h20, 32'h0));
        sb.push_back(mk(1'b1, 32'h20, 32'hBEEF3344));
        run_op(c_sh, 32'h0000_0022, 32'h0000_BEEF, lat, e);
        ack_delay = 0;
        tests++;
        if (lat !== 10 || e !== 1'b0) begin
            fails++;
            $display("FAIL sh_delay: got lat=%0d err=%b expected lat=10 err=0", lat, e);
        end
    endtask

    task automatic test_lanes;
        int lat; logic e;
        logic [5:0]  opcs [6] = '{c_sb, c_sb, c_sb, c_sb, c_sh, c_sh};
        logic [1:0]  offs [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd2};
        logic [31:0] a, d;
        for (int i = 0; i < 6; i++) begin
            rd_val = $urandom;
            d      = $urandom;
            a      = {$urandom_range(0, 255), 4'h0, 2'b00} + 32'(offs[i]);
            sb.push_back(mk(1'b0, a, 32'h0));
            sb.push_back(mk(1'b1, a, merge_ref(opcs[i], a, d, rd_val)));
            run_op(opcs[i], a, d, lat, e);
            tests++;
            if (lat !== 4 || e !== 1'b0) begin
                fails++;
                $display("FAIL lane_%0d: got lat=%0d err=%b expected lat=4 err=0", i, lat, e);
            end
        end
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL lanes_sb: %0d accesses outstanding, expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_timeout;
        int lat; int req0;
        ack_en = 1'b0;
        req0   = req_cycles;
        @(negedge clk);
        start = 1'b1; opcode = c_sw; addr = 32'h40; store_data = 32'h12345678;
        @(posedge clk);
        #1 opcode = c_sb;
        lat = -1;
        for (int k = 1; k <= 64; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = k;
                tests++;
                if (err !== 1'b1) begin
                    fails++;
                    $display("FAIL timeout_err: got err=%b expected 1", err);
                end
                break;
            end
        end
        start = 1'b0;
        tests++;
        if (lat !== 17) begin
            fails++;
            $display("FAIL timeout_lat: got lat=%0d expected 17", lat);
        end
        tests++;
        if (req_cycles - req0 !== 16) begin
            fails++;
            $display("FAIL timeout_req: got %0d request cycles expected 16", req_cycles - req0);
        end
        repeat (3) @(negedge clk);
        tests++;
        if (busy !== 1'b0 || req_cycles - req0 !== 16) begin
            fails++;
            $display("FAIL timeout_idle: got busy=%b req=%0d expected 0/16", busy, req_cycles - req0);
        end
        ack_en = 1'b1;
    endtask

    task automatic test_bad_opcode;
        int lat; logic e; int req0;
        req0 = req_cycles;
        run_op(6'h24, 32'h10, 32'h55, lat, e);
        tests++;
        if (lat !== 1 || e !== 1'b1 || req_cycles !== req0) begin
            fails++;
            $display("FAIL bad_opcode: got lat=%0d err=%b req=%0d expected lat=1 err=1 req=0", lat, e, req_cycles - req0);
        end
    endtask

    task automatic test_misalign;
        int lat; logic e; int req0;
        req0   = req_cycles;
        rd_val = 32'hA1B2C3D4;
`ifdef STORE_ALIGN_CHECK_EN
        run_op(c_sw, 32'h0000_0012, 32'hCAFEF00D, lat, e);
        tests++;
        if (lat !== 1 || e !== 1'b1 || req_cycles !== req0) begin
            fails++;
            $display("FAIL misalign_sw: got lat=%0d err=%b req=%0d expected lat=1 err=1 req=0", lat, e, req_cycles - req0);
        end
        run_op(c_sh, 32'h0000_0021, 32'h0000_9876, lat, e);
        tests++;
        if (lat !== 1 || e !== 1'b1 || req_cycles !== req0) begin
            fails++;
            $display("FAIL misalign_sh: got lat=%0d err=%b req=%0d expected lat=1 err=1 req=0", lat, e, req_cycles - req0);
        end
`else
        sb.push_back(mk(1'b1, 32'h10, 32'hCAFEF00D));
        run_op(c_sw, 32'h0000_0012, 32'hCAFEF00D, lat, e);
        tests++;
        if (lat !== 2 || e !== 1'b0) begin
            fails++;
            $display("FAIL misalign_sw: got lat=%0d err=%b expected lat=2 err=0", lat, e);
        end
        sb.push_back(mk(1'b0, 32'h20, 32'h0));
        sb.push_back(mk(1'b1, 32'h20, 32'hA1B29876));
        run_op(c_sh, 32'h0000_0021, 32'h0000_9876, lat, e);
        tests++;
        if (lat !== 4 || e !== 1'b0) begin
            fails++;
            $display("FAIL misalign_sh: got lat=%0d err=%b expected lat=4 err=0", lat, e);
        end
`endif
    endtask

    task automatic test_reset_mid;
        int lat; logic e; logic seen; logic saw_done;
        ack_delay = 6;
        rd_val    = 32'h01020304;
        sb.push_back(mk(1'b0, 32'h30, 32'h0));
        sb.push_back(mk(1'b1, 32'h30, 32'h01FF0304));
        @(negedge clk);
        start = 1'b1; opcode = c_sb; addr = 32'h32; store_data = 32'hFF;
        @(posedge clk);
        #1 start = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (mem_req === 1'b1 && mem_we === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        tests++;
        if (seen !== 1'b1) begin
            fails++;
            $display("FAIL rst_mid_wr: write phase not reached, got 0 expected 1");
        end
        #2 reset = 1'b1;
        #1;
        tests++;
        if (mem_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid_drop: got req=%b busy=%b done=%b expected 0/0/0", mem_req, busy, done);
        end
        saw_done = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (done !== 1'b0) saw_done = 1'b1;
        end
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (done !== 1'b0) saw_done = 1'b1;
        end
        tests++;
        if (saw_done !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid_nodone: got done pulse 1 expected 0");
        end
        sb.delete();
        ack_delay = 0;
        sb.push_back(mk(1'b1, 32'h44, 32'h0BADF00D));
        run_op(c_sw, 32'h0000_0044, 32'h0BADF00D, lat, e);
        tests++;
        if (lat !== 2 || e !== 1'b0 || sb.size() != 0) begin
            fails++;
            $display("FAIL rst_mid_after: got lat=%0d err=%b pending=%0d expected 2/0/0", lat, e, sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_sw();
        test_sb();
        test_sh_delay();
        test_lanes();
        test_timeout();
        test_bad_opcode();
        test_misalign();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
